// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared front-end definitions: sequencer state encoding and the PC
// geometry used by both the fetch stage and the redirect controller.
package branch_redirect_ctrl_pkg;

    localparam int          CORE_PC_W     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

    // 2'b11 is unused and decodes back to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PEND   = 2'b01,
        ST_SHADOW = 2'b10
    } redirect_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Execute-stage redirect request, stall request and front-end controls.
//   master : drives ex_valid, ex_pc_sel, ex_branch_pc, stall_req
//   slave  : drives pc, fd_we, dx_we, fd_flush, dx_flush, in_shadow, redirect_cnt
interface branch_redirect_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic             ex_pc_sel;
    logic [PC_W-1:0]  ex_branch_pc;
    logic             stall_req;
    logic [PC_W-1:0]  pc;
    logic             fd_we;
    logic             dx_we;
    logic             fd_flush;
    logic             dx_flush;
    logic             in_shadow;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output ex_valid, ex_pc_sel, ex_branch_pc, stall_req,
        input  pc, fd_we, dx_we, fd_flush, dx_flush, in_shadow, redirect_cnt
    );

    modport slave (
        input  ex_valid, ex_pc_sel, ex_branch_pc, stall_req,
        output pc, fd_we, dx_we, fd_flush, dx_flush, in_shadow, redirect_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl_redirect_counter.sv
// Saturating up-counter for applied redirects.
//   clock, reset : rising-edge clock, async active-high reset
//   inc          : count one event this cycle
//   count        : current value, sticks at all-ones
module redirect_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end sequencer: owns the fetch PC, applies execute-stage redirects,
// flushes the wrong-path F/D and D/X contents, and arbitrates redirects
// against stall requests.
//   clock, reset : rising-edge clock, async active-high reset
//   bus.ex_*     : execute-stage valid, taken flag and target
//   bus.stall_req: hold the front end
//   bus.pc       : registered fetch PC
//   bus.*_we     : latch write enables; bus.*_flush: load nop at next edge
//   bus.in_shadow, bus.redirect_cnt : status / perf readout
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal fetch, redirects accepted
// ST_PEND   | redirect accepted during a stall, target parked in pend_q
// ST_SHADOW | post-redirect window, execute-stage decisions ignored
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int              PC_W          = CORE_PC_W,
    parameter logic [PC_W-1:0] RESET_PC      = PC_W'(CORE_RESET_PC),
    parameter int              SHADOW_CYCLES = 2,
    parameter int              CNT_W         = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_redirect_ctrl_if.slave bus
);
    localparam int SH_W = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(SHADOW_CYCLES);

    redirect_state_e state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [PC_W-1:0] pend_q, pend_nxt;
    logic [SH_W-1:0] sh_q, sh_nxt;
    logic [PC_W-1:0] pc_inc;
    logic            qualify;
    logic            redir_go;
    logic [PC_W-1:0] redir_tgt;
    logic            we;
    logic            flush;

    assign pc_inc  = pc_q + PC_W'(1);
    assign qualify = bus.ex_valid & bus.ex_pc_sel & (state != ST_SHADOW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            pc_q   <= RESET_PC;
            pend_q <= '0;
            sh_q   <= '0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            pend_q <= pend_nxt;
            sh_q   <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_q;
        sh_nxt    = sh_q;
        we        = 1'b0;
        flush     = 1'b0;
        redir_go  = 1'b0;
        redir_tgt = bus.ex_branch_pc;

        case (state)
            ST_RUN: begin
                if (bus.stall_req) begin
                    if (qualify) begin
                        pend_nxt  = bus.ex_branch_pc;
                        state_nxt = ST_PEND;
                    end
                end else if (qualify) begin
                    redir_go = 1'b1;
                end else begin
                    we     = 1'b1;
                    pc_nxt = pc_inc;
                end
            end
            // The parked target wins over anything new from execute.
            ST_PEND: begin
                if (!bus.stall_req) begin
                    redir_go  = 1'b1;
                    redir_tgt = pend_q;
                end
            end
            ST_SHADOW: begin
                if (!bus.stall_req) begin
                    we     = 1'b1;
                    pc_nxt = pc_inc;
                    sh_nxt = sh_q - SH_W'(1);
                    if (sh_q <= SH_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (redir_go) begin
            we        = 1'b1;
            flush     = 1'b1;
            pc_nxt    = redir_tgt;
            sh_nxt    = SH_LOAD;
            state_nxt = (SHADOW_CYCLES > 0) ? ST_SHADOW : ST_RUN;
        end
    end

    redirect_counter #(.CNT_W(CNT_W)) u_redirect_counter (
        .clock (clock),
        .reset (reset),
        .inc   (redir_go),
        .count (bus.redirect_cnt)
    );

    assign bus.pc        = pc_q;
    assign bus.fd_we     = we;
    assign bus.dx_we     = we;
    assign bus.fd_flush  = flush;
    assign bus.dx_flush  = flush;
    assign bus.in_shadow = (state == ST_SHADOW);
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
    localparam int SHADOW = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    branch_redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(
        .PC_W          (PC_W),
        .RESET_PC      (32'h0),
        .SHADOW_CYCLES (SHADOW),
        .CNT_W         (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic        flush;
        logic        in_shadow;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: what the front end has promised so far.
    logic [31:0] m_pc;
    bit          m_pending;
    logic [31:0] m_pend_tgt;
    int          m_shadow_left;
    int          m_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc          = 32'h0;
        m_pending     = 1'b0;
        m_pend_tgt    = 32'h0;
        m_shadow_left = 0;
        m_cnt         = 0;
    endtask

    // Called at posedge+1: drive this cycle's inputs, record what the DUT
    // must show before the next edge, advance the model, then move to the
    // next posedge+1.
    task automatic cycle(input bit v, input bit sel, input logic [31:0] tgt, input bit stall);
        exp_t e;
        bit   take;
        logic [31:0] take_tgt;
        bus.ex_valid     = v;
        bus.ex_pc_sel    = sel;
        bus.ex_branch_pc = tgt;
        bus.stall_req    = stall;

        e.pc        = m_pc;
        e.cnt       = m_cnt;
        e.in_shadow = (m_shadow_left > 0);
        e.we        = 1'b0;
        e.flush     = 1'b0;
        take        = 1'b0;
        take_tgt    = tgt;

        if (m_pending) begin
            if (!stall) begin
                take     = 1'b1;
                take_tgt = m_pend_tgt;
            end
        end else if (m_shadow_left > 0) begin
            if (!stall) begin
                e.we = 1'b1;
                m_pc = m_pc + 32'd1;
                m_shadow_left--;
            end
        end else if (v && sel) begin
            if (stall) begin
                m_pending  = 1'b1;
                m_pend_tgt = tgt;
            end else begin
                take = 1'b1;
            end
        end else if (!stall) begin
            e.we = 1'b1;
            m_pc = m_pc + 32'd1;
        end

        if (take) begin
            e.we          = 1'b1;
            e.flush       = 1'b1;
            m_pc          = take_tgt;
            m_pending     = 1'b0;
            m_shadow_left = SHADOW;
            if (m_cnt < CNT_MAX) m_cnt++;
        end

        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clock) begin
        if (!reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",           bus.pc,           e.pc);
            check("fd_we",        bus.fd_we,        e.we);
            check("dx_we",        bus.dx_we,        e.we);
            check("fd_flush",     bus.fd_flush,     e.flush);
            check("dx_flush",     bus.dx_flush,     e.flush);
            check("in_shadow",    bus.in_shadow,    e.in_shadow);
            check("redirect_cnt", bus.redirect_cnt, e.cnt);
        end
    end

    initial begin
        bus.ex_valid     = 1'b0;
        bus.ex_pc_sel    = 1'b0;
        bus.ex_branch_pc = '0;
        bus.stall_req    = 1'b0;
        reset            = 1'b1;
        model_reset();
        #2;
        check("reset_pc",  bus.pc, 32'h0);
        check("reset_cnt", bus.redirect_cnt, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        idle(5);

        while (m_pc != 32'h10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b0);
        idle(3);

        cycle(1'b1, 1'b1, 32'h80, 1'b1);
        cycle(1'b1, 1'b1, 32'h99, 1'b1);
        cycle(1'b1, 1'b1, 32'h99, 1'b1);
        cycle(1'b1, 1'b1, 32'h99, 1'b0);
        idle(3);

        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 1'b1, 32'h200, 1'b0);
        idle(3);

        cycle(1'b0, 1'b1, 32'h300, 1'b0);
        cycle(1'b1, 1'b0, 32'h300, 1'b0);

        cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        idle(4);

        for (int i = 0; i < CNT_MAX + 3; i++) begin
            cycle(1'b1, 1'b1, 32'h1000 + 32'(i * 16), 1'b0);
            idle(2);
        end

        // Asynchronous reset while a redirect is parked.
        cycle(1'b1, 1'b1, 32'h80, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc",        bus.pc, 32'h0);
        check("async_rst_in_shadow", bus.in_shadow, 0);
        check("async_rst_flush",     bus.fd_flush, 0);
        check("async_rst_cnt",       bus.redirect_cnt, 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(4);

        for (int i = 0; i < 400; i++) begin
            bit v, sel, stall;
            logic [31:0] tgt;
            v     = ($urandom_range(0, 3) != 0);
            sel   = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 9) < 3);
            tgt   = $urandom;
            cycle(v, sel, tgt, stall);
        end

        repeat (2) @(negedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
